pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Second-generation hazard and forwarding controller for the five-stage RV32I pipeline (IF/ID/EX/DM/WB). It adds three things:
- a per-register scoreboard for a variable-latency multiply/divide unit (MDU);
- whole-pipeline freeze on a data-memory wait handshake;
- prioritised forwarding selects and a defined priority between stalls and flushes.

It sits beside the datapath and drives the stall and clear inputs of every pipeline register bank.

Parameters:
REG_ADDR_WIDTH, 5, register address width; scoreboard depth NUM_REGS = 2**REG_ADDR_WIDTH
CNT_WIDTH, 32, width of performance counters (only with the optional feature)

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
rs1_addr_id_i, rs2_addr_id_i  in  REG_ADDR_WIDTH  ID-stage source addresses
rs1_used_id_i, rs2_used_id_i  in  1  ID instruction actually reads rs1/rs2
rd_addr_id_i  in  REG_ADDR_WIDTH  ID-stage destination
reg_write_enable_id_i  in  1  ID instruction writes rd
mdu_op_id_i  in  1  ID instruction is an MDU op
rs1_addr_ex_i, rs2_addr_ex_i  in  REG_ADDR_WIDTH  EX-stage sources
rd_addr_ex_i  in  REG_ADDR_WIDTH  EX destination
load_ex_i  in  1  EX instruction is a load
rd_addr_dm_i, rd_addr_wb_i  in  REG_ADDR_WIDTH  DM/WB destinations
reg_write_enable_dm_i, reg_write_enable_wb_i  in  1  DM/WB write enables
load_dm_i  in  1  DM instruction is a memory access
dmem_ready_i  in  1  data memory has completed the DM access this cycle
branch_enable_i  in  1  taken branch/jump resolved in EX
mdu_issue_i  in  1  MDU op leaves EX this cycle
mdu_issue_rd_i  in  REG_ADDR_WIDTH  destination of issued MDU op
mdu_busy_i  in  1  MDU cannot accept a new op
mdu_done_i  in  1  MDU writes its result this cycle
mdu_done_rd_i  in  REG_ADDR_WIDTH  destination of completed MDU op
stall_pc_if_o, stall_if_id_o, stall_id_ex_o, stall_ex_dm_o  out  1  hold respective register
clear_if_id_o, clear_id_ex_o, clear_dm_wb_o  out  1  bubble-insert respective register
rs1_fwd_sel_o, rs2_fwd_sel_o  out  2  00 regfile, 01 from DM, 10 from WB
sb_pending_o  out  NUM_REGS  scoreboard pending bits

Behaviour:
- Scoreboard is the only state, aside from the optional counters. It is one pending bit per register.
  - Reset clears it to 0.
  - mdu_issue_i with rd != 0 sets bit rd on the next edge.
  - mdu_done_i clears bit mdu_done_rd_i.
  - Issue and done to the same rd in the same cycle: set wins.
  - Bit 0 is never set.
- Forwarding, per source, for EX source address s:
  - s == 0 -> 00.
  - s == rd_dm and reg_write_enable_dm_i -> 01. DM has priority.
  - else s == rd_wb and reg_write_enable_wb_i -> 10.
  - else 00.
  - Value 11 is never produced.
- mem_stall = load_dm_i and not dmem_ready_i.
- load_use = load_ex_i and rd_ex != 0 and ((rs1_used and rs1_id == rd_ex) or (rs2_used and rs2_id == rd_ex)).
- sb_stall is asserted when any of the following holds:
  - rs1_used and pending[rs1_id];
  - rs2_used and pending[rs2_id];
  - reg_write_enable_id and pending[rd_id] (WAW);
  - mdu_op_id and mdu_busy_i.
- Priority, evaluated combinationally each cycle:
  1. mem_stall: all four stall outputs 1, clear_dm_wb_o 1, all other clears 0. Branch is held in EX and acted on once the freeze ends.
  2. branch_enable_i: clear_if_id_o = clear_id_ex_o = 1, no stalls. Branch overrides load_use and sb_stall because the ID instruction is on the wrong path.
  3. load_use or sb_stall: stall_pc_if_o = stall_if_id_o = 1, clear_id_ex_o = 1.
  4. Otherwise all stall and clear outputs are 0.
- Latency:
  - load_use costs exactly 1 bubble.
  - sb_stall persists until the mdu_done_i cycle. The dependent instruction leaves ID on the edge after done, using WB forwarding or the regfile.
- Reset:
  - Asynchronous clear of the scoreboard and counters.
  - While reset_n_i is low, all stall and clear outputs are 0, fwd selects are 00, and sb_pending_o is 0.
  - Reset mid-MDU-operation discards pending bits; a late mdu_done_i after reset is harmless.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles_o, flush_count_o, mem_wait_cycles_o (each CNT_WIDTH).
  - stall_cycles_o counts cycles with load_use or sb_stall taking effect at priority 3.
  - flush_count_o counts cycles where priority 2 is active.
  - mem_wait_cycles_o counts mem_stall cycles.
  - All three saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Forwarding priority: rs1_ex = 5 with rd_dm = 5 (we 1) and rd_wb = 5 (we 1) -> rs1_fwd_sel_o = 01. With rs2_ex = 0 and rd_dm = 0 (we 1) -> 00.
- Load-use: load_ex with rd_ex = 7, rs2_id = 7 used -> exactly 1 cycle of stall_pc/if_id = 1 and clear_id_ex = 1. Same with rs2_used = 0 -> no stall.
- MDU scoreboard:
  - Issue rd = 9 at cycle 0; ID reads x9 from cycle 1 -> stall held until the mdu_done_i(rd = 9) cycle, released on the next cycle.
  - Same-cycle issue and done on rd = 9 -> pending stays 1.
- Memory freeze: load_dm with dmem_ready_i low for 3 cycles and branch_enable_i = 1 -> 3 cycles with all stalls = 1, clear_dm_wb = 1, clear_if_id = 0. On the first ready cycle -> clear_if_id = clear_id_ex = 1.
- Branch vs. load-use in the same cycle -> clears asserted, stall_pc_if_o = 0.
- Async reset asserted with pending[3] = 1 mid-stall -> sb_pending_o = 0 immediately and all outputs 0. With HAZARD_PERF_CNT_EN, counters read 0 after reset and saturate when preloaded near max.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage RV32I pipeline: MDU scoreboard,
// data-memory freeze, forwarding selects. Define HAZARD_PERF_CNT_EN for perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rs1_addr_id_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rs2_addr_id_i,
  input  logic                        rs1_used_id_i,
  input  logic                        rs2_used_id_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_id_i,
  input  logic                        reg_write_enable_id_i,
  input  logic                        mdu_op_id_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rs1_addr_ex_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rs2_addr_ex_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_ex_i,
  input  logic                        load_ex_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_dm_i,
  input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_wb_i,
  input  logic                        reg_write_enable_dm_i,
  input  logic                        reg_write_enable_wb_i,
  input  logic                        load_dm_i,
  input  logic                        dmem_ready_i,
  input  logic                        branch_enable_i,
  input  logic                        mdu_issue_i,
  input  logic [REG_ADDR_WIDTH-1:0]   mdu_issue_rd_i,
  input  logic                        mdu_busy_i,
  input  logic                        mdu_done_i,
  input  logic [REG_ADDR_WIDTH-1:0]   mdu_done_rd_i,
  output logic                        stall_pc_if_o,
  output logic                        stall_if_id_o,
  output logic                        stall_id_ex_o,
  output logic                        stall_ex_dm_o,
  output logic                        clear_if_id_o,
  output logic                        clear_id_ex_o,
  output logic                        clear_dm_wb_o,
  output logic [1:0]                  rs1_fwd_sel_o,
  output logic [1:0]                  rs2_fwd_sel_o,
  output logic [2**REG_ADDR_WIDTH-1:0] sb_pending_o
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0]      stall_cycles_o
  , output logic [CNT_WIDTH-1:0]      flush_count_o
  , output logic [CNT_WIDTH-1:0]      mem_wait_cycles_o
`endif
);

  localparam int unsigned NUM_REGS = 2**REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_DM = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_e;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] issue_mask, done_mask;
  logic                mem_stall, load_use, sb_stall;
  logic                prio_branch, prio_hazard;
  fwd_sel_e            rs1_fwd, rs2_fwd;

  // Done clears first, issue sets afterwards so a same-cycle issue+done keeps the bit.
  always_comb begin
    issue_mask = '0;
    done_mask  = '0;
    if (mdu_issue_i) issue_mask[mdu_issue_rd_i] = 1'b1;
    if (mdu_done_i)  done_mask[mdu_done_rd_i]   = 1'b1;
    pending_d    = (pending_q & ~done_mask) | issue_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pending_q <= '0;
    else            pending_q <= pending_d;
  end

  assign sb_pending_o = pending_q;

  function automatic fwd_sel_e fwd_sel(input logic [REG_ADDR_WIDTH-1:0] src,
                                       input logic [REG_ADDR_WIDTH-1:0] rd_dm,
                                       input logic [REG_ADDR_WIDTH-1:0] rd_wb,
                                       input logic we_dm, input logic we_wb);
    if (src == '0)                 return FWD_RF;
    else if (we_dm && src == rd_dm) return FWD_DM;
    else if (we_wb && src == rd_wb) return FWD_WB;
    else                            return FWD_RF;
  endfunction

  assign rs1_fwd = fwd_sel(rs1_addr_ex_i, rd_addr_dm_i, rd_addr_wb_i,
                           reg_write_enable_dm_i, reg_write_enable_wb_i);
  assign rs2_fwd = fwd_sel(rs2_addr_ex_i, rd_addr_dm_i, rd_addr_wb_i,
                           reg_write_enable_dm_i, reg_write_enable_wb_i);
  assign rs1_fwd_sel_o = reset_n_i ? rs1_fwd : FWD_RF;
  assign rs2_fwd_sel_o = reset_n_i ? rs2_fwd : FWD_RF;

  assign mem_stall = load_dm_i && !dmem_ready_i;
  assign load_use  = load_ex_i && (rd_addr_ex_i != '0) &&
                     ((rs1_used_id_i && rs1_addr_id_i == rd_addr_ex_i) ||
                      (rs2_used_id_i && rs2_addr_id_i == rd_addr_ex_i));
  assign sb_stall  = (rs1_used_id_i && pending_q[rs1_addr_id_i]) ||
                     (rs2_used_id_i && pending_q[rs2_addr_id_i]) ||
                     (reg_write_enable_id_i && pending_q[rd_addr_id_i]) ||
                     (mdu_op_id_i && mdu_busy_i);

  always_comb begin
    stall_pc_if_o = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    stall_ex_dm_o = 1'b0;
    clear_if_id_o = 1'b0;
    clear_id_ex_o = 1'b0;
    clear_dm_wb_o = 1'b0;
    prio_branch   = 1'b0;
    prio_hazard   = 1'b0;
    if (!reset_n_i) begin
      prio_branch = 1'b0;
    end else if (mem_stall) begin
      stall_pc_if_o = 1'b1;
      stall_if_id_o = 1'b1;
      stall_id_ex_o = 1'b1;
      stall_ex_dm_o = 1'b1;
      clear_dm_wb_o = 1'b1;
    end else if (branch_enable_i) begin
      prio_branch   = 1'b1;
      clear_if_id_o = 1'b1;
      clear_id_ex_o = 1'b1;
    end else if (load_use || sb_stall) begin
      prio_hazard   = 1'b1;
      stall_pc_if_o = 1'b1;
      stall_if_id_o = 1'b1;
      clear_id_ex_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, memw_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      memw_cnt_q  <= '0;
    end else begin
      if (prio_hazard && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (prio_branch && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      if (mem_stall   && memw_cnt_q  != '1) memw_cnt_q  <= memw_cnt_q  + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles_o    = stall_cnt_q;
  assign flush_count_o     = flush_cnt_q;
  assign mem_wait_cycles_o = memw_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle reference model plus
// hand-computed directed expectations.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic [4:0] rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i;
  logic       rs1_used_id_i, rs2_used_id_i, reg_write_enable_id_i, mdu_op_id_i;
  logic [4:0] rs1_addr_ex_i, rs2_addr_ex_i, rd_addr_ex_i;
  logic       load_ex_i;
  logic [4:0] rd_addr_dm_i, rd_addr_wb_i;
  logic       reg_write_enable_dm_i, reg_write_enable_wb_i, load_dm_i, dmem_ready_i;
  logic       branch_enable_i, mdu_issue_i, mdu_busy_i, mdu_done_i;
  logic [4:0] mdu_issue_rd_i, mdu_done_rd_i;
  logic       stall_pc_if_o, stall_if_id_o, stall_id_ex_o, stall_ex_dm_o;
  logic       clear_if_id_o, clear_id_ex_o, clear_dm_wb_o;
  logic [1:0] rs1_fwd_sel_o, rs2_fwd_sel_o;
  logic [31:0] sb_pending_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_o, flush_count_o, mem_wait_cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .rs1_addr_id_i(rs1_addr_id_i), .rs2_addr_id_i(rs2_addr_id_i),
    .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
    .rd_addr_id_i(rd_addr_id_i), .reg_write_enable_id_i(reg_write_enable_id_i),
    .mdu_op_id_i(mdu_op_id_i),
    .rs1_addr_ex_i(rs1_addr_ex_i), .rs2_addr_ex_i(rs2_addr_ex_i),
    .rd_addr_ex_i(rd_addr_ex_i), .load_ex_i(load_ex_i),
    .rd_addr_dm_i(rd_addr_dm_i), .rd_addr_wb_i(rd_addr_wb_i),
    .reg_write_enable_dm_i(reg_write_enable_dm_i),
    .reg_write_enable_wb_i(reg_write_enable_wb_i),
    .load_dm_i(load_dm_i), .dmem_ready_i(dmem_ready_i),
    .branch_enable_i(branch_enable_i),
    .mdu_issue_i(mdu_issue_i), .mdu_issue_rd_i(mdu_issue_rd_i),
    .mdu_busy_i(mdu_busy_i), .mdu_done_i(mdu_done_i), .mdu_done_rd_i(mdu_done_rd_i),
    .stall_pc_if_o(stall_pc_if_o), .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o), .stall_ex_dm_o(stall_ex_dm_o),
    .clear_if_id_o(clear_if_id_o), .clear_id_ex_o(clear_id_ex_o),
    .clear_dm_wb_o(clear_dm_wb_o),
    .rs1_fwd_sel_o(rs1_fwd_sel_o), .rs2_fwd_sel_o(rs2_fwd_sel_o),
    .sb_pending_o(sb_pending_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    , .mem_wait_cycles_o(mem_wait_cycles_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference scoreboard: set of registers with an MDU result outstanding.
  bit model_pend [32];

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      foreach (model_pend[i]) model_pend[i] <= 1'b0;
    end else begin
      if (mdu_done_i) model_pend[mdu_done_rd_i] <= 1'b0;
      if (mdu_issue_i && mdu_issue_rd_i != 0) model_pend[mdu_issue_rd_i] <= 1'b1;
    end
  end

  function automatic logic [1:0] ref_fwd(input int s);
    if (s == 0) return 2'd0;
    if (reg_write_enable_dm_i && s == int'(rd_addr_dm_i)) return 2'd1;
    if (reg_write_enable_wb_i && s == int'(rd_addr_wb_i)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [6:0] ctrl_vec();
    return {stall_pc_if_o, stall_if_id_o, stall_id_ex_o, stall_ex_dm_o,
            clear_if_id_o, clear_id_ex_o, clear_dm_wb_o};
  endfunction

  always @(negedge clk_i) begin
    logic [6:0]  exp_ctrl;
    logic [31:0] exp_pend;
    logic [1:0]  exp_f1, exp_f2;
    bit mem, lu, sb;
    exp_ctrl = '0;
    exp_f1 = '0;
    exp_f2 = '0;
    for (int i = 0; i < 32; i++) exp_pend[i] = model_pend[i];
    if (reset_n_i) begin
      mem = load_dm_i && !dmem_ready_i;
      lu  = load_ex_i && rd_addr_ex_i != 0 &&
            ((rs1_used_id_i && rs1_addr_id_i == rd_addr_ex_i) ||
             (rs2_used_id_i && rs2_addr_id_i == rd_addr_ex_i));
      sb  = (rs1_used_id_i && model_pend[rs1_addr_id_i]) ||
            (rs2_used_id_i && model_pend[rs2_addr_id_i]) ||
            (reg_write_enable_id_i && model_pend[rd_addr_id_i]) ||
            (mdu_op_id_i && mdu_busy_i);
      if (mem)                  exp_ctrl = 7'b1111_001;
      else if (branch_enable_i) exp_ctrl = 7'b0000_110;
      else if (lu || sb)        exp_ctrl = 7'b1100_010;
      exp_f1 = ref_fwd(int'(rs1_addr_ex_i));
      exp_f2 = ref_fwd(int'(rs2_addr_ex_i));
    end
    check("model_ctrl", ctrl_vec(), exp_ctrl);
    check("model_fwd1", rs1_fwd_sel_o, exp_f1);
    check("model_fwd2", rs2_fwd_sel_o, exp_f2);
    check("model_pend", sb_pending_o, exp_pend);
  end

  task automatic idle();
    {rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i} = '0;
    {rs1_used_id_i, rs2_used_id_i, reg_write_enable_id_i, mdu_op_id_i} = '0;
    {rs1_addr_ex_i, rs2_addr_ex_i, rd_addr_ex_i, load_ex_i} = '0;
    {rd_addr_dm_i, rd_addr_wb_i, reg_write_enable_dm_i, reg_write_enable_wb_i} = '0;
    load_dm_i = 1'b0;
    dmem_ready_i = 1'b1;
    {branch_enable_i, mdu_issue_i, mdu_busy_i, mdu_done_i} = '0;
    {mdu_issue_rd_i, mdu_done_rd_i} = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    idle();
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_ctrl", ctrl_vec(), 7'b0);
    check("rst_pend", sb_pending_o, 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_cnt", {stall_cycles_o, flush_count_o, mem_wait_cycles_o}, 64'h0);
`endif
    step();
    reset_n_i = 1'b1;

    // Forwarding
    rs1_addr_ex_i = 5; rd_addr_dm_i = 5; reg_write_enable_dm_i = 1;
    rd_addr_wb_i = 5; reg_write_enable_wb_i = 1; #1;
    check("fwd_dm_prio", rs1_fwd_sel_o, 2'b01);
    step();
    rd_addr_dm_i = 0; rs2_addr_ex_i = 0; #1;
    check("fwd_x0", rs2_fwd_sel_o, 2'b00);
    check("fwd_wb", rs1_fwd_sel_o, 2'b10);
    step();
    reg_write_enable_wb_i = 0; rs2_addr_ex_i = 5; #1;
    check("fwd_none", rs1_fwd_sel_o, 2'b00);

    // Load-use
    step(); idle();
    load_ex_i = 1; rd_addr_ex_i = 7; rs2_addr_id_i = 7; rs2_used_id_i = 1; #1;
    check("lu_stall", ctrl_vec(), 7'b1100_010);
    step();
    load_ex_i = 0; rd_addr_ex_i = 0; load_dm_i = 1; rd_addr_dm_i = 7; #1;
    check("lu_one_bubble", ctrl_vec(), 7'b0);
    step(); idle();
    load_ex_i = 1; rd_addr_ex_i = 7; rs2_addr_id_i = 7; rs2_used_id_i = 0; #1;
    check("lu_unused", ctrl_vec(), 7'b0);

    // MDU scoreboard
    step(); idle();
    mdu_issue_i = 1; mdu_issue_rd_i = 9; #1;
    check("sb_issue_cycle", sb_pending_o, 32'h0);
    step(); idle();
    rs1_addr_id_i = 9; rs1_used_id_i = 1; #1;
    check("sb_set", sb_pending_o, 32'h200);
    check("sb_stall1", ctrl_vec(), 7'b1100_010);
    step(); #1;
    check("sb_stall2", ctrl_vec(), 7'b1100_010);
    step();
    mdu_done_i = 1; mdu_done_rd_i = 9; #1;
    check("sb_done_cycle", ctrl_vec(), 7'b1100_010);
    step();
    mdu_done_i = 0; #1;
    check("sb_release", ctrl_vec(), 7'b0);
    check("sb_cleared", sb_pending_o, 32'h0);
    step(); idle();
    mdu_issue_i = 1; mdu_issue_rd_i = 9; mdu_done_i = 1; mdu_done_rd_i = 9;
    step(); idle(); #1;
    check("sb_set_wins", sb_pending_o, 32'h200);
    mdu_done_i = 1; mdu_done_rd_i = 9;
    step(); idle(); #1;
    check("sb_clear", sb_pending_o, 32'h0);
    mdu_issue_i = 1; mdu_issue_rd_i = 4;
    step(); idle();
    reg_write_enable_id_i = 1; rd_addr_id_i = 4; #1;
    check("sb_waw", ctrl_vec(), 7'b1100_010);
    step();
    mdu_done_i = 1; mdu_done_rd_i = 4;
    step(); idle();
    mdu_op_id_i = 1; mdu_busy_i = 1; #1;
    check("sb_busy", ctrl_vec(), 7'b1100_010);
    step(); idle();
    mdu_issue_i = 1; mdu_issue_rd_i = 0;
    step(); idle(); #1;
    check("sb_x0", sb_pending_o, 32'h0);

    // Memory freeze holding a taken branch
    load_dm_i = 1; dmem_ready_i = 0; branch_enable_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("freeze", ctrl_vec(), 7'b1111_001);
      step();
    end
    dmem_ready_i = 1; #1;
    check("freeze_release_branch", ctrl_vec(), 7'b0000_110);

    // Branch beats load-use
    step(); idle();
    branch_enable_i = 1; load_ex_i = 1; rd_addr_ex_i = 7;
    rs1_addr_id_i = 7; rs1_used_id_i = 1; #1;
    check("branch_over_lu", ctrl_vec(), 7'b0000_110);

    // Async reset in the middle of a scoreboard stall
    step(); idle();
    mdu_issue_i = 1; mdu_issue_rd_i = 3;
    step(); idle();
    rs1_addr_id_i = 3; rs1_used_id_i = 1;
    rs1_addr_ex_i = 6; rd_addr_dm_i = 6; reg_write_enable_dm_i = 1; #1;
    check("pre_rst_stall", ctrl_vec(), 7'b1100_010);
    reset_n_i = 1'b0; #1;
    check("rst_async_pend", sb_pending_o, 32'h0);
    check("rst_async_ctrl", ctrl_vec(), 7'b0);
    check("rst_async_fwd", rs1_fwd_sel_o, 2'b00);
    step(); step();
    reset_n_i = 1'b1;
    mdu_done_i = 1; mdu_done_rd_i = 3; #1;
    check("late_done", ctrl_vec(), 7'b0);
    step(); idle(); #1;
    check("late_done_pend", sb_pending_o, 32'h0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
